capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl.sv | 106 ++++++++++
 tb/tb_capture_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for a 512-entry circular trace RAM: decimated pre-trigger fill,
// trigger arming, post-trigger countdown and trace_end reporting.
module capture_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture_start,
  input  logic       dump_busy,
  input  logic [3:0] decimator,
  input  logic [8:0] trig_pos,
  input  logic       triggered,
  output logic       cap_en,
  output logic       we,
  output logic [8:0] cap_addr,
  output logic [8:0] trace_end,
  output logic       busy,
  output logic       armed,
  output logic       capture_done
);

  typedef enum logic [1:0] {IDLE, PREFILL, ARMED, POST} state_t;

  state_t      state, state_nxt;
  logic [3:0]  dec_q;
  logic [8:0]  tp_q;
  logic [15:0] dcnt;
  logic [15:0] dec_mask;
  logic [8:0]  wptr;
  logic [9:0]  pre_cnt;
  logic [9:0]  pre_target;
  logic [8:0]  post_cnt;
  logic        start_ok;
  logic        post_full;
  logic        strobe;
  logic        finish;

  assign dec_mask   = 16'((17'd1 << dec_q) - 17'd1);
  assign pre_target = 10'd512 - {1'b0, tp_q};
  assign post_full  = (post_cnt == tp_q);
  // The completion cycle itself still counts as busy for a new request.
  assign start_ok   = (state == IDLE) && capture_start && !dump_busy && !capture_done;

  assign busy  = (state != IDLE);
  assign armed = (state == ARMED);
  assign we    = cap_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    // Once all post-trigger strobes are issued, POST only waits for the last write to land.
    strobe    = (dcnt == dec_mask) &&
                ((state == PREFILL) || (state == ARMED) || ((state == POST) && !post_full));
    case (state)
      IDLE:    if (start_ok) state_nxt = PREFILL;
      PREFILL: if (strobe && ((pre_cnt + 10'd1) == pre_target)) state_nxt = ARMED;
      ARMED: begin
        // A strobe in the accepting cycle must still reach the RAM before going idle.
        if (triggered) state_nxt = ((tp_q == 9'd0) && !strobe) ? IDLE : POST;
      end
      POST:    if (post_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    finish = (state != IDLE) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en       <= 1'b0;
      cap_addr     <= 9'd0;
      trace_end    <= 9'd0;
      capture_done <= 1'b0;
      dec_q        <= 4'd0;
      tp_q         <= 9'd0;
      dcnt         <= 16'd0;
      wptr         <= 9'd0;
      pre_cnt      <= 10'd0;
      post_cnt     <= 9'd0;
    end else begin
      cap_en       <= strobe;
      capture_done <= finish;
      if (strobe) begin
        cap_addr <= wptr;
        wptr     <= wptr + 9'd1;
        dcnt     <= 16'd0;
      end else if (state != IDLE) begin
        dcnt <= dcnt + 16'd1;
      end
      if (strobe && (state == PREFILL)) pre_cnt  <= pre_cnt + 10'd1;
      if (strobe && (state == POST))    post_cnt <= post_cnt + 9'd1;
      if (finish) trace_end <= wptr - 9'd1;
      if (start_ok) begin
        dec_q    <= decimator;
        tp_q     <= trig_pos;
        wptr     <= 9'd0;
        dcnt     <= 16'd0;
        pre_cnt  <= 10'd0;
        post_cnt <= 9'd0;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized bench for capture_ctrl; expected outputs come from a closed-form
// timeline of each capture (strobe times, arming, trigger acceptance, completion).
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       capture_start;
  logic       dump_busy;
  logic [3:0] decimator;
  logic [8:0] trig_pos;
  logic       triggered;
  logic       cap_en;
  logic       we;
  logic [8:0] cap_addr;
  logic [8:0] trace_end;
  logic       busy;
  logic       armed;
  logic       capture_done;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_te = 0;

  always #5 clk = ~clk;

  capture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_start(capture_start),
    .dump_busy    (dump_busy),
    .decimator    (decimator),
    .trig_pos     (trig_pos),
    .triggered    (triggered),
    .cap_en       (cap_en),
    .we           (we),
    .cap_addr     (cap_addr),
    .trace_end    (trace_end),
    .busy         (busy),
    .armed        (armed),
    .capture_done (capture_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},   32'(busy),         32'd0);
    chk({tag, ".armed"},  32'(armed),        32'd0);
    chk({tag, ".cap_en"}, 32'(cap_en),       32'd0);
    chk({tag, ".we"},     32'(we),           32'd0);
    chk({tag, ".done"},   32'(capture_done), 32'd0);
  endtask

  // Ignored requests: start with dump_busy high, then plain idle cycles.
  task automatic idle_blocked(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      capture_start = 1'b1;
      dump_busy     = 1'b1;
      triggered     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_quiet("dump_blk");
      chk("dump_blk.te", 32'(trace_end), 32'(prev_te));
    end
    @(posedge clk); #1;
    capture_start = 1'b0;
    dump_busy     = 1'b0;
  endtask

  // Timeline (t = 0 is the start cycle, P = 2^dec):
  //   strobe i at t = (i+1)*P, its write visible at t+1 with address i mod 512;
  //   armed from the cycle after write (512-tp) is strobed; trigger accepted at
  //   A = first armed cycle with trigger high; k = strobes at or before A.
  task automatic run_capture(input int dec, input int tp, input int trig_t, input int abort_t);
    int P, as_t, A, k, W, dn, te, t_end, idx;
    bit exp_en;
    P    = 1 << dec;
    as_t = (512 - tp) * P + 1;
    A    = (trig_t > as_t) ? trig_t : as_t;
    k    = A / P;
    W    = k + tp;
    if (tp > 0) dn = W * P + 2;
    else        dn = ((A % P) == 0) ? A + 2 : A + 1;
    te    = (W - 1) % 512;
    t_end = (abort_t > 0) ? abort_t : dn + 2;
    for (int t = 0; t <= t_end; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        capture_start = 1'b1;
        dump_busy     = 1'b0;
        decimator     = 4'(dec);
        trig_pos      = 9'(tp);
      end else begin
        capture_start = (t <= dn) ? ($urandom_range(0, 7) == 0) : 1'b0;
        dump_busy     = 1'($urandom_range(0, 1));
        decimator     = 4'($urandom);
        trig_pos      = 9'($urandom);
      end
      if (t >= as_t && t <= A) triggered = (t >= trig_t);
      else                     triggered = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_en = (t >= P + 1) && (((t - 1) % P) == 0) && (((t - 1) / P - 1) < W);
      idx    = (t - 1) / P - 1;
      chk("busy",      32'(busy),         32'(t >= 1 && t < dn));
      chk("armed",     32'(armed),        32'(t >= as_t && t <= A));
      chk("done",      32'(capture_done), 32'(t == dn));
      chk("cap_en",    32'(cap_en),       32'(exp_en));
      chk("we",        32'(we),           32'(exp_en));
      if (exp_en) chk("cap_addr", 32'(cap_addr), 32'(idx % 512));
      chk("trace_end", 32'(trace_end),    32'((t >= dn) ? te : prev_te));
      if (abort_t > 0 && t == abort_t) begin
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("rst_async");
        chk("rst_async.addr", 32'(cap_addr),  32'd0);
        chk("rst_async.te",   32'(trace_end), 32'd0);
        capture_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_te = 0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          triggered = 1'($urandom_range(0, 1));
          dump_busy = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk_quiet("post_rst");
          chk("post_rst.te", 32'(trace_end), 32'd0);
        end
        return;
      end
    end
    prev_te = te;
  endtask

  initial begin
    int d, tp, tr;
    rst_n         = 1'b0;
    capture_start = 1'b0;
    dump_busy     = 1'b0;
    decimator     = 4'd0;
    trig_pos      = 9'd0;
    triggered     = 1'b0;
    #12;
    chk_quiet("reset");
    chk("reset.addr", 32'(cap_addr),  32'd0);
    chk("reset.te",   32'(trace_end), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idle_blocked(4);
    run_capture(0, 256, 300, 0);
    chk("te_k300", 32'(trace_end), 32'd43);
    run_capture(2, 511, int'($urandom_range(1, 60)), 0);
    run_capture(0, 0, 520, 0);
    chk("te_tp0", 32'(trace_end), 32'd7);
    idle_blocked(3);
    run_capture(0, 256, 260, 362);
    for (int r = 0; r < 3; r++) begin
      d  = int'($urandom_range(0, 2));
      tp = int'($urandom_range(0, 511));
      tr = int'($urandom_range(1, (512 - tp) * (1 << d) + 200));
      run_capture(d, tp, tr, 0);
    end
    run_capture(1, 0, int'($urandom_range(1, 1100)), 0);
    idle_blocked(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
